// File: rtl/clk_gate_en_ctrl_pkg.sv
// Shared types and constants for the idle-detect clock-gate enable controller.
// State encodings match the gated-clock controller family (2'd3 is unused and recovers to ACTIVE).
package clk_gate_en_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_GATED  = 2'd1,
    ST_WAKE   = 2'd2,
    ST_RSVD   = 2'd3
  } state_e;

  localparam int unsigned WAKE_DLY_MIN = 1;
  localparam int unsigned WAKE_DLY_MAX = 15;
  localparam int unsigned WAKE_CNT_W   = 4;

  function automatic logic wake_dly_ok(input int unsigned dly);
    return (dly >= WAKE_DLY_MIN) && (dly <= WAKE_DLY_MAX);
  endfunction

endpackage

// File: rtl/clk_gate_en_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
// Used for the idle counter and the gated-cycle statistics counter.
module sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/clk_gate_en_ctrl.sv
// Idle-detect controller driving module_en of a downstream clock gate, on the ungated clock.
// Optional gated-cycle statistics counter and its ports are built when CLK_GATE_STATS_EN is defined.
module clk_gate_en_ctrl
  import clk_gate_en_ctrl_pkg::*;
#(
  parameter int unsigned IDLE_W   = 8,
  parameter int unsigned WAKE_DLY = 2,
  parameter int unsigned STAT_W   = 16
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              cfg_auto_en,
  input  logic [IDLE_W-1:0] cfg_idle_thresh,
  input  logic              busy,
  input  logic              wake_req,
`ifdef CLK_GATE_STATS_EN
  input  logic              stats_clr,
`endif
  output logic              module_en,
  output logic              gated,
  output logic              wake_ack,
`ifdef CLK_GATE_STATS_EN
  output logic [STAT_W-1:0] gated_cycles,
`endif
  output state_e            dbg_state,
  output logic [IDLE_W-1:0] dbg_idle_cnt
);

  if (!wake_dly_ok(WAKE_DLY)) begin : g_bad_wake_dly
    $error("clk_gate_en_ctrl: WAKE_DLY must be in 1..15");
  end

  localparam logic [WAKE_CNT_W-1:0] WAKE_LAST = WAKE_CNT_W'(WAKE_DLY - 1);

  state_e                  state_q, state_d;
  logic [WAKE_CNT_W-1:0]   wake_cnt_q, wake_cnt_d;
  logic                    module_en_q, module_en_d;
  logic                    gated_q, gated_d;
  logic                    wake_ack_q, wake_ack_d;

  logic                    idle;
  logic                    thresh_hit;
  logic                    idle_inc;
  logic                    idle_clr;
  logic [IDLE_W-1:0]       idle_cnt;
  logic [IDLE_W-1:0]       thresh_m1;

  assign idle       = cfg_auto_en & (cfg_idle_thresh != '0) & ~busy & ~wake_req;
  assign thresh_m1  = cfg_idle_thresh - IDLE_W'(1);
  // >= rather than == so a threshold lowered mid-count still gates promptly
  assign thresh_hit = (idle_cnt >= thresh_m1);

  sat_cnt #(.W(IDLE_W)) u_idle_cnt (
    .clk (clk_in),
    .rst (rst),
    .inc (idle_inc),
    .clr (idle_clr),
    .q   (idle_cnt)
  );

  always_comb begin
    state_d    = state_q;
    wake_cnt_d = '0;
    wake_ack_d = 1'b0;
    idle_inc   = 1'b0;
    idle_clr   = 1'b1;
    case (state_q)
      ST_ACTIVE: begin
        if (idle) begin
          if (thresh_hit) begin
            state_d = ST_GATED;
          end else begin
            idle_inc = 1'b1;
            idle_clr = 1'b0;
          end
        end
      end
      ST_GATED: begin
        if (busy || wake_req || !cfg_auto_en) begin
          state_d = ST_WAKE;
        end
      end
      ST_WAKE: begin
        // WAKE always runs to completion; inputs cannot abort or restart it
        if (wake_cnt_q == WAKE_LAST) begin
          state_d    = ST_ACTIVE;
          wake_ack_d = 1'b1;
        end else begin
          wake_cnt_d = wake_cnt_q + WAKE_CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_ACTIVE;
      end
    endcase
    module_en_d = (state_d != ST_GATED);
    gated_d     = (state_d == ST_GATED);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= ST_ACTIVE;
      wake_cnt_q  <= '0;
      module_en_q <= 1'b1;
      gated_q     <= 1'b0;
      wake_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wake_cnt_q  <= wake_cnt_d;
      module_en_q <= module_en_d;
      gated_q     <= gated_d;
      wake_ack_q  <= wake_ack_d;
    end
  end

`ifdef CLK_GATE_STATS_EN
  sat_cnt #(.W(STAT_W)) u_gated_cycles (
    .clk (clk_in),
    .rst (rst),
    .inc (state_q == ST_GATED),
    .clr (stats_clr),
    .q   (gated_cycles)
  );
`endif

  assign module_en    = module_en_q;
  assign gated        = gated_q;
  assign wake_ack     = wake_ack_q;
  assign dbg_state    = state_q;
  assign dbg_idle_cnt = idle_cnt;

endmodule

// File: tb/tb_clk_gate_en_ctrl.sv
// Directed self-checking bench for clk_gate_en_ctrl (IDLE_W=8, WAKE_DLY=2).
// Statistics scenario is built only when CLK_GATE_STATS_EN is defined.
module tb_clk_gate_en_ctrl;
  import clk_gate_en_ctrl_pkg::*;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       cfg_auto_en;
  logic [7:0] cfg_idle_thresh;
  logic       busy;
  logic       wake_req;
  logic       module_en;
  logic       gated;
  logic       wake_ack;
  state_e     dbg_state;
  logic [7:0] dbg_idle_cnt;
`ifdef CLK_GATE_STATS_EN
  logic       stats_clr;
  logic [3:0] gated_cycles;
`endif

  // {module_en, gated, wake_ack}
  wire [2:0] outs = {module_en, gated, wake_ack};

  int n_checks = 0;
  int n_pass   = 0;

  // clock / reset
  always #5 clk_in = ~clk_in;

  clk_gate_en_ctrl #(
    .IDLE_W   (8),
    .WAKE_DLY (2)
`ifdef CLK_GATE_STATS_EN
    , .STAT_W (4)
`endif
  ) dut (
    .clk_in          (clk_in),
    .rst             (rst),
    .cfg_auto_en     (cfg_auto_en),
    .cfg_idle_thresh (cfg_idle_thresh),
    .busy            (busy),
    .wake_req        (wake_req),
`ifdef CLK_GATE_STATS_EN
    .stats_clr       (stats_clr),
`endif
    .module_en       (module_en),
    .gated           (gated),
    .wake_ack        (wake_ack),
`ifdef CLK_GATE_STATS_EN
    .gated_cycles    (gated_cycles),
`endif
    .dbg_state       (dbg_state),
    .dbg_idle_cnt    (dbg_idle_cnt)
  );

  // driver tasks: outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; cfg_auto_en = 1'b0; cfg_idle_thresh = 8'd0; busy = 1'b0; wake_req = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Reach GATED in one cycle with thresh=1
  task automatic enter_gated();
    reset_dut();
    cfg_auto_en = 1'b1; cfg_idle_thresh = 8'd1;
    tick();
    n_checks++;
    if (outs !== 3'b010 || dbg_state !== ST_GATED)
      $display("FAIL enter_gated: outs=%b state=%0d required outs=010 state=1", outs, dbg_state);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_auto_en = 1'b0; cfg_idle_thresh = 8'd4; busy = 1'b0; wake_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (outs !== 3'b100 || dbg_state !== ST_ACTIVE || dbg_idle_cnt !== 8'd0)
        $display("FAIL reset_hold[%0d]: outs=%b state=%0d cnt=%0d required 100/0/0", k, outs, dbg_state, dbg_idle_cnt);
      else n_pass++;
    end
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_checks++;
      if (outs !== 3'b100)
        $display("FAIL reset_no_gate[%0d]: outs=%b required 100", k, outs);
      else n_pass++;
    end
  endtask

  task automatic test_gate_entry();
    reset_dut();
    cfg_auto_en = 1'b1; cfg_idle_thresh = 8'd4;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_checks++;
      if (k < 4) begin
        if (outs !== 3'b100 || dbg_idle_cnt !== 8'(k))
          $display("FAIL gate_entry[c%0d]: outs=%b cnt=%0d required 100 cnt=%0d", k, outs, dbg_idle_cnt, k);
        else n_pass++;
      end else begin
        if (outs !== 3'b010 || dbg_idle_cnt !== 8'd0)
          $display("FAIL gate_entry[c%0d]: outs=%b cnt=%0d required 010 cnt=0", k, outs, dbg_idle_cnt);
        else n_pass++;
      end
    end
  endtask

  task automatic test_wake_busy();
    enter_gated();
    busy = 1'b1;
    tick();
    busy = 1'b0;
    n_checks++;
    if (outs !== 3'b100 || dbg_state !== ST_WAKE)
      $display("FAIL wake_n1: outs=%b state=%0d required 100 state=2", outs, dbg_state);
    else n_pass++;
    tick();
    n_checks++;
    if (outs !== 3'b100 || dbg_state !== ST_WAKE)
      $display("FAIL wake_n2: outs=%b state=%0d required 100 state=2", outs, dbg_state);
    else n_pass++;
    tick();
    n_checks++;
    if (outs !== 3'b101 || dbg_state !== ST_ACTIVE || dbg_idle_cnt !== 8'd0)
      $display("FAIL wake_n3: outs=%b state=%0d cnt=%0d required 101/0/0", outs, dbg_state, dbg_idle_cnt);
    else n_pass++;
    cfg_auto_en = 1'b0;
    tick();
    n_checks++;
    if (outs !== 3'b100)
      $display("FAIL wake_n4: outs=%b required 100", outs);
    else n_pass++;
  endtask

  task automatic test_wake_req();
    enter_gated();
    wake_req = 1'b1;
    tick();
    tick();
    n_checks++;
    if (outs !== 3'b100)
      $display("FAIL wake_req_n2: outs=%b required 100", outs);
    else n_pass++;
    tick();
    n_checks++;
    if (outs !== 3'b101 || dbg_state !== ST_ACTIVE)
      $display("FAIL wake_req_ack: outs=%b state=%0d required 101 state=0", outs, dbg_state);
    else n_pass++;
    // wake_req held in ACTIVE: no ack, counter stays clear, no gating
    tick();
    tick();
    n_checks++;
    if (outs !== 3'b100 || dbg_idle_cnt !== 8'd0)
      $display("FAIL wake_req_active: outs=%b cnt=%0d required 100 cnt=0", outs, dbg_idle_cnt);
    else n_pass++;
    wake_req = 1'b0;
  endtask

  task automatic test_wake_cfg_off();
    enter_gated();
    cfg_auto_en = 1'b0;
    tick();
    n_checks++;
    if (outs !== 3'b100 || dbg_state !== ST_WAKE)
      $display("FAIL cfg_off_wake: outs=%b state=%0d required 100 state=2", outs, dbg_state);
    else n_pass++;
  endtask

  task automatic test_race();
    reset_dut();
    cfg_auto_en = 1'b1; cfg_idle_thresh = 8'd3;
    tick();
    tick();
    busy = 1'b1;
    tick();
    busy = 1'b0;
    n_checks++;
    if (outs !== 3'b100 || dbg_state !== ST_ACTIVE || dbg_idle_cnt !== 8'd0)
      $display("FAIL race_busy: outs=%b state=%0d cnt=%0d required 100/0/0", outs, dbg_state, dbg_idle_cnt);
    else n_pass++;
    tick();
    tick();
    n_checks++;
    if (outs !== 3'b100 || dbg_idle_cnt !== 8'd2)
      $display("FAIL race_recount: outs=%b cnt=%0d required 100 cnt=2", outs, dbg_idle_cnt);
    else n_pass++;
    tick();
    n_checks++;
    if (outs !== 3'b010)
      $display("FAIL race_gate: outs=%b required 010", outs);
    else n_pass++;
  endtask

  task automatic test_reset_mid_wake();
    enter_gated();
    busy = 1'b1;
    tick();
    busy = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cfg_auto_en = 1'b0;
    n_checks++;
    if (outs !== 3'b100 || dbg_state !== ST_ACTIVE || dbg_idle_cnt !== 8'd0)
      $display("FAIL rst_wake: outs=%b state=%0d cnt=%0d required 100/0/0", outs, dbg_state, dbg_idle_cnt);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (outs !== 3'b100)
        $display("FAIL rst_wake_no_ack[%0d]: outs=%b required 100", k, outs);
      else n_pass++;
    end
  endtask

  task automatic test_thresh_change();
    reset_dut();
    cfg_auto_en = 1'b1; cfg_idle_thresh = 8'd8;
    for (int k = 0; k < 5; k++) tick();
    n_checks++;
    if (outs !== 3'b100 || dbg_idle_cnt !== 8'd5)
      $display("FAIL thresh_pre: outs=%b cnt=%0d required 100 cnt=5", outs, dbg_idle_cnt);
    else n_pass++;
    cfg_idle_thresh = 8'd2;
    tick();
    n_checks++;
    if (outs !== 3'b010)
      $display("FAIL thresh_lowered: outs=%b required 010", outs);
    else n_pass++;
    // zero threshold disables gating altogether
    reset_dut();
    cfg_auto_en = 1'b1; cfg_idle_thresh = 8'd0;
    for (int k = 0; k < 10; k++) tick();
    n_checks++;
    if (outs !== 3'b100 || dbg_idle_cnt !== 8'd0)
      $display("FAIL thresh_zero: outs=%b cnt=%0d required 100 cnt=0", outs, dbg_idle_cnt);
    else n_pass++;
  endtask

`ifdef CLK_GATE_STATS_EN
  task automatic test_stats();
    stats_clr = 1'b0;
    enter_gated();
    n_checks++;
    if (gated_cycles !== 4'd0)
      $display("FAIL stats_start: got %0d required 0", gated_cycles);
    else n_pass++;
    for (int k = 0; k < 3; k++) tick();
    n_checks++;
    if (gated_cycles !== 4'd3)
      $display("FAIL stats_count: got %0d required 3", gated_cycles);
    else n_pass++;
    for (int k = 0; k < 17; k++) tick();
    n_checks++;
    if (gated_cycles !== 4'd15)
      $display("FAIL stats_sat: got %0d required 15", gated_cycles);
    else n_pass++;
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    n_checks++;
    if (gated_cycles !== 4'd0)
      $display("FAIL stats_clr: got %0d required 0", gated_cycles);
    else n_pass++;
  endtask
`endif

  initial begin
`ifdef CLK_GATE_STATS_EN
    stats_clr = 1'b0;
`endif
    test_reset();
    test_gate_entry();
    test_wake_busy();
    test_wake_req();
    test_wake_cfg_off();
    test_race();
    test_reset_mid_wake();
    test_thresh_change();
`ifdef CLK_GATE_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
